// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared FSM state type and default tap constant for the bounded LFSR draw block
package lfsr_pkg;

  typedef enum logic [1:0] {
    LFSR_IDLE = 2'd0,
    LFSR_DRAW = 2'd1,
    LFSR_RESP = 2'd2
  } lfsr_state_e;

  // Default 8-bit feedback taps: state bits 7, 6, 5 and 0.
  localparam logic [7:0] LFSR_TAPS_8 = 8'hE1;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR state register with seed load and single step
module lfsr_core #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'hE1,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] base;

  // A load replaces the state first (zero seed would lock up, so it maps to RESET_SEED);
  // a simultaneous step then advances from the freshly loaded value.
  always_comb begin
    base = state_q;
    if (load_i) begin
      base = (seed_i == '0) ? RESET_SEED : seed_i;
    end
    state_d = base;
    if (step_i) begin
      state_d = {base[WIDTH-2:0], ^(base & TAPS)};
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RESET_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_range.sv
// rtl/lfsr_range.sv - bounded random draws from an LFSR via rejection sampling with fallback
module lfsr_range
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = LFSR_TAPS_8,
  parameter int               OUT_W      = 5,
  parameter int               MAX_TRIES  = 8,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             seed_valid_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [OUT_W-1:0] bound_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [OUT_W-1:0] rand_o
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  lfsr_state_e      fsm_q, fsm_d;
  logic [OUT_W-1:0] bound_q, bound_d;
  logic [OUT_W-1:0] rand_q, rand_d;
  logic [TRY_W-1:0] tries_q, tries_d;

  logic             step, load;
  logic [WIDTH-1:0] lfsr_state;
  logic [OUT_W-1:0] bound_m1, mask, cand;
  logic             accept, last_try;
  logic             unused_state_bits;

  lfsr_core #(
    .WIDTH      (WIDTH),
    .TAPS       (TAPS),
    .RESET_SEED (RESET_SEED)
  ) u_core (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .step_i  (step),
    .load_i  (load),
    .seed_i  (seed_i),
    .state_o (lfsr_state)
  );

  // Only the low OUT_W state bits feed the candidate.
  assign unused_state_bits = ^(lfsr_state >> OUT_W);

  // Smear bound-1 rightwards to get the smallest 2^k-1 covering it; bound 0 wraps to all ones.
  always_comb begin
    bound_m1 = bound_q - OUT_W'(1);
    mask     = bound_m1;
    for (int i = 1; i < OUT_W; i++) begin
      mask = mask | (bound_m1 >> i);
    end
  end

  assign cand     = lfsr_state[OUT_W-1:0] & mask;
  assign accept   = (bound_q == '0) || (cand < bound_q);
  assign last_try = !((int'(tries_q) + 1) < MAX_TRIES);

  // Next-state logic: accept in IDLE, examine candidates in DRAW, hold result in RESP.
  always_comb begin
    fsm_d   = fsm_q;
    bound_d = bound_q;
    rand_d  = rand_q;
    tries_d = tries_q;
    step    = 1'b0;
    load    = 1'b0;
    unique case (fsm_q)
      LFSR_IDLE: begin
        load = seed_valid_i;
        if (req_valid_i) begin
          bound_d = bound_i;
          step    = 1'b1;
          tries_d = '0;
          fsm_d   = LFSR_DRAW;
        end
      end
      LFSR_DRAW: begin
        if (accept) begin
          rand_d = cand;
          fsm_d  = LFSR_RESP;
        end else if (!last_try) begin
          step    = 1'b1;
          tries_d = tries_q + TRY_W'(1);
        end else begin
          // cand lies in [bound, 2*bound-2] here, so the difference stays below bound.
          rand_d = cand - bound_q;
          fsm_d  = LFSR_RESP;
        end
      end
      LFSR_RESP: begin
        if (rsp_ready_i) begin
          fsm_d = LFSR_IDLE;
        end
      end
      default: fsm_d = LFSR_IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q   <= LFSR_IDLE;
      bound_q <= '0;
      rand_q  <= '0;
      tries_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      bound_q <= bound_d;
      rand_q  <= rand_d;
      tries_q <= tries_d;
    end
  end

  assign req_ready_o = (fsm_q == LFSR_IDLE);
  assign rsp_valid_o = (fsm_q == LFSR_RESP);
  assign rand_o      = rand_q;

endmodule

// File: tb/tb_lfsr_range.sv
// tb/tb_lfsr_range.sv - directed self-checking bench for lfsr_range
module tb_lfsr_range;

  logic       clk;
  logic       rst_n;

  logic       seed_valid;
  logic [7:0] seed;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] bound;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rand_v;

  logic       seed_valid2;
  logic [7:0] seed2;
  logic       req_valid2;
  logic       req_ready2;
  logic [4:0] bound2;
  logic       rsp_valid2;
  logic       rsp_ready2;
  logic [4:0] rand2;

  int checks;
  int failures;

  lfsr_range dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .seed_valid_i (seed_valid),
    .seed_i       (seed),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .bound_i      (bound),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rand_o       (rand_v)
  );

  lfsr_range #(.MAX_TRIES(2)) dut2 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .seed_valid_i (seed_valid2),
    .seed_i       (seed2),
    .req_valid_i  (req_valid2),
    .req_ready_o  (req_ready2),
    .bound_i      (bound2),
    .rsp_valid_o  (rsp_valid2),
    .rsp_ready_i  (rsp_ready2),
    .rand_o       (rand2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Latency is counted in cycles from the cycle the request is presented.
  task automatic run_req(input string tag, input logic [4:0] b, input bit sd, input logic [7:0] sv,
                         input int hold, input logic [4:0] exp_r, input int exp_lat);
    int cyc;
    @(negedge clk);
    expect_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    bound      = b;
    seed_valid = sd;
    seed       = sv;
    @(negedge clk);
    req_valid  = 1'b0;
    seed_valid = 1'b0;
    bound      = '0;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    expect_eq({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    expect_eq({tag, "_rand"}, 32'(rand_v), 32'(exp_r));
    for (int i = 0; i < hold; i++) begin
      seed_valid = 1'b1;
      seed       = 8'h55;
      @(negedge clk);
      expect_eq({tag, "_hold_rand"}, 32'(rand_v), 32'(exp_r));
      expect_eq({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
      expect_eq({tag, "_hold_vld"}, 32'(rsp_valid), 32'd1);
    end
    seed_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    rsp_ready  = 1'b0;
  endtask

  initial begin
    int cyc;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    seed_valid  = 1'b0;
    seed        = '0;
    req_valid   = 1'b0;
    bound       = '0;
    rsp_ready   = 1'b0;
    seed_valid2 = 1'b0;
    seed2       = '0;
    req_valid2  = 1'b0;
    bound2      = '0;
    rsp_ready2  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    expect_eq("rst_req_ready", 32'(req_ready), 32'd1);
    expect_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    expect_eq("rst_rand", 32'(rand_v), 32'd0);
    rst_n = 1'b1;

    // Full-range draws: states 03 then 07
    run_req("full1", 5'd0, 1'b0, 8'h00, 0, 5'd3, 2);
    run_req("full2", 5'd0, 1'b0, 8'h00, 0, 5'd7, 2);

    // Rejection sampling: five rejects of 3, then 0x7E & 3 = 2
    do_reset();
    run_req("reject", 5'd3, 1'b0, 8'h00, 0, 5'd2, 7);

    // Fallback on the 2-try instance: 3,3 rejected -> 3-3 = 0, state left at 07
    do_reset();
    @(negedge clk);
    req_valid2 = 1'b1;
    bound2     = 5'd3;
    @(negedge clk);
    req_valid2 = 1'b0;
    bound2     = '0;
    cyc = 1;
    while (!rsp_valid2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    expect_eq("fallback_lat", 32'(cyc), 32'd3);
    expect_eq("fallback_rand", 32'(rand2), 32'd0);
    rsp_ready2 = 1'b1;
    @(negedge clk);
    rsp_ready2 = 1'b0;
    // Next full-range draw steps 07 -> 0F
    req_valid2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
    cyc = 1;
    while (!rsp_valid2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    expect_eq("fallback_next_rand", 32'(rand2), 32'h0F);
    rsp_ready2 = 1'b1;
    @(negedge clk);
    rsp_ready2 = 1'b0;

    // Seed handling: zero seed acts as 01; seed+request steps from the new seed
    do_reset();
    @(negedge clk);
    seed_valid = 1'b1;
    seed       = 8'h00;
    @(negedge clk);
    seed_valid = 1'b0;
    run_req("seed_zero", 5'd0, 1'b0, 8'h00, 0, 5'd3, 2);
    run_req("seed_with_req", 5'd0, 1'b1, 8'h1F, 0, 5'h1F, 2);

    // Backpressure with an ignored seed pulse during RESP
    do_reset();
    run_req("bp", 5'd0, 1'b0, 8'h00, 5, 5'd3, 2);
    run_req("bp_after", 5'd0, 1'b0, 8'h00, 0, 5'd7, 2);

    // Reset mid-DRAW
    do_reset();
    @(negedge clk);
    req_valid = 1'b1;
    bound     = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    bound     = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    expect_eq("middraw_ready", 32'(req_ready), 32'd1);
    expect_eq("middraw_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    run_req("middraw_after", 5'd0, 1'b0, 8'h00, 0, 5'd3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_range.md
# lfsr_range

Parametrised pseudo-random generator that answers bounded draw requests. A Fibonacci LFSR of configurable width and taps is sampled through valid/ready request and response handshakes. Each request returns a value uniformly drawn from `[0, bound)` by rejection sampling, with a deterministic fallback after a configurable number of tries. It replaces the fixed 8-bit free-running generator in game and testbench logic that needs range-limited random values and runtime reseeding.

## Interface
- `WIDTH`, 8: LFSR state width, 2..32.
- `TAPS`, 8'hE1: feedback tap mask, `WIDTH` bits; bit i set means state[i] is included in the XOR.
- `OUT_W`, 5: output and bound width; must satisfy `OUT_W <= WIDTH`.
- `MAX_TRIES`, 8: maximum number of candidates examined per request, at least 1.
- `RESET_SEED`, 1: state value after reset and substitute for a zero seed; must be nonzero.
- `clk_i` input, 1: clock, single domain.
- `rst_ni` input, 1: reset, synchronous, active-low.
- `seed_valid_i` input, 1: load `seed_i` into the state; honoured only in IDLE.
- `seed_i` input, `WIDTH`: new seed; zero is replaced by `RESET_SEED`.
- `req_valid_i` input, 1: draw request.
- `req_ready_o` output, 1: high only in IDLE.
- `bound_i` input, `OUT_W`: exclusive upper bound; 0 means 2^`OUT_W` (full range).
- `rsp_valid_o` output, 1: result valid; high only in RESP.
- `rsp_ready_i` input, 1: consumer accepts the result.
- `rand_o` output, `OUT_W`: result; held stable while `rsp_valid_o` is high.

## Operation
- **Step rule:** `fb = ^(state & TAPS)`. Next state is `{state[WIDTH-2:0], fb}`. The state changes only on a step or a seed load.
- **Candidate:** `cand = state[OUT_W-1:0] & mask`.
  - `mask` is the smallest (2^k − 1) with `mask >= bound-1`.
  - For `bound == 0`, `mask` is all ones.
  - For `bound == 1`, `mask` is 0.
- **FSM states:** IDLE, DRAW, RESP.
- **IDLE:**
  - `req_ready_o = 1`.
  - On `seed_valid_i`, load the seed (zero becomes `RESET_SEED`).
  - On `req_valid_i`:
    - Latch `bound_i`.
    - Step the state. If a seed load happens in the same cycle, the step is applied to the new seed.
    - Clear the try counter and go to DRAW.
- **DRAW:** evaluate `cand` from the current state.
  - **Accept:** if `bound == 0` or `cand < bound`, latch `rand_o = cand` and go to RESP.
  - **Reject with tries left:** if rejected and `tries + 1 < MAX_TRIES`, step the state, increment `tries`, and stay in DRAW.
  - **Reject on last try:** latch `rand_o = cand - bound` (always `< bound`) and go to RESP. The state is not stepped.
- **RESP:**
  - `rsp_valid_o = 1`.
  - Ignore `seed_valid_i`.
  - On `rsp_ready_i`, go to IDLE.
- **Reset values:** state = `RESET_SEED`, FSM = IDLE, `rsp_valid_o = 0`, `rand_o = 0`, `req_ready_o = 1`.
- **Reset mid-operation:** the same values are restored in the next cycle and any pending draw is dropped.

## Timing
- A request is accepted on the edge where `req_valid_i && req_ready_o`. That edge also performs the first step.
- DRAW lasts N cycles, where N is the accepting try index (1..`MAX_TRIES`).
- `rsp_valid_o` rises N+1 cycles after the accept edge, so the minimum latency is 2 cycles.
- Throughput: one response handshake at most every N+2 cycles. There is no request/response overlap.
- `rsp_ready_i` high on the first RESP cycle returns the block to IDLE on the next edge. `req_ready_o` is therefore high one cycle after the response handshake.
- All outputs are driven from registers; there are no combinational input-to-output paths.

## Structure
- **`lfsr_pkg`:** FSM state enum (`LFSR_IDLE`, `LFSR_DRAW`, `LFSR_RESP`) and a default taps constant `LFSR_TAPS_8 = 8'hE1`.
- **`lfsr_core`** (params `WIDTH`, `TAPS`, `RESET_SEED`):
  - Holds the state register.
  - Inputs: `step_i`, `load_i`, `seed_i`. Load wins over step, and load+step means step from the loaded seed.
  - Output: `state_o`.
- **`lfsr_range`:** wraps `lfsr_core` and adds the FSM, bound/mask logic and the try counter (`$clog2(MAX_TRIES+1)` bits).

## Test plan
All scenarios use the defaults `WIDTH=8`, `TAPS=8'hE1`, `OUT_W=5`. The state sequence from reset is 01, 03, 07, 0F, 1F, 3F, 7E.

- **Full-range draws:** reset, then two requests with `bound=0` → `rand_o = 3`, then `rand_o = 7`; each `rsp_valid_o` rises 2 cycles after accept.
- **Rejection sampling:** reset, `MAX_TRIES=8`, request `bound=3` → candidates 3, 3, 3, 3, 3 are rejected and 0x7E gives 2, which is accepted → `rand_o = 2`, `rsp_valid_o` 7 cycles after accept.
- **Fallback:** reset, `MAX_TRIES=2`, request `bound=3` → two rejects (3, 3) → `rand_o = 0`, final state 0x07.
- **Seed handling:** seed load of 0 → behaves as 0x01. Seed 0x1F together with a request (`bound=0`) in the same cycle → `rand_o = 0x1F`, taken from state 0x3F & 0x1F.
- **Backpressure:** hold `rsp_ready_i=0` for 5 cycles → `rand_o` stable, `req_ready_o = 0`; `seed_valid_i` pulsed during RESP is ignored.
- **Reset mid-DRAW:** assert `rst_ni=0` while in DRAW → next cycle IDLE, `rsp_valid_o = 0`; a following `bound=0` request returns 3.
